// File: rtl/vga_timing_gen_if.sv
// Renderer/DAC-side bundle of the VGA raster engine.
// The timing generator owns the master modport; the renderer/DAC side uses slave.
interface vga_timing_gen_if #(
    parameter int COLOR_W = 8,
    parameter int X_W     = 10,
    parameter int Y_W     = 10,
    parameter int FCNT_W  = 16
);
    logic               start;
    logic [COLOR_W-1:0] red_in;
    logic [COLOR_W-1:0] green_in;
    logic [COLOR_W-1:0] blue_in;
    logic [X_W-1:0]     pixel_x;
    logic [Y_W-1:0]     pixel_y;
    logic               pixel_req;
    logic [COLOR_W-1:0] red_out;
    logic [COLOR_W-1:0] green_out;
    logic [COLOR_W-1:0] blue_out;
    logic               hsync;
    logic               vsync;
    logic               n_blank;
    logic               vgaclock;
    logic               frame_start;
    logic [FCNT_W-1:0]  frame_count;

    modport master (
        input  start, red_in, green_in, blue_in,
        output pixel_x, pixel_y, pixel_req, red_out, green_out, blue_out,
        output hsync, vsync, n_blank, vgaclock, frame_start, frame_count
    );

    modport slave (
        output start, red_in, green_in, blue_in,
        input  pixel_x, pixel_y, pixel_req, red_out, green_out, blue_out,
        input  hsync, vsync, n_blank, vgaclock, frame_start, frame_count
    );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster engine: pixel-rate divider, h/v counters, pixel requests
// and a one-pixel-delayed, blank-masked DAC output stage.
module vga_timing_gen #(
    parameter int COLOR_W  = 8,
    parameter int CLK_DIV  = 2,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int H_POL    = 0,
    parameter int V_POL    = 0,
    parameter int FCNT_W   = 16
) (
    input  logic           clock_50,
    input  logic           reset,
    vga_timing_gen_if.master vga
);
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int X_W      = $clog2(H_TOTAL);
    localparam int Y_W      = $clog2(V_TOTAL);
    localparam int DIV_W    = $clog2(CLK_DIV);
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = H_ACTIVE + H_FP + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = V_ACTIVE + V_FP + V_SYNC;
    localparam logic HP     = (H_POL != 0);
    localparam logic VP     = (V_POL != 0);

    typedef enum logic {IDLE, RUN} state_t;

    state_t               state_reg, state_next;
    logic [DIV_W-1:0]     div_cnt_reg, div_cnt_next;
    logic [X_W-1:0]       h_cnt_reg;
    logic [Y_W-1:0]       v_cnt_reg;
    logic [FCNT_W-1:0]    frame_count_reg;
    logic                 frame_start_reg;
    logic                 vgaclock_reg;
    logic                 n_blank_reg;
    logic                 hsync_reg;
    logic                 vsync_reg;
    logic [COLOR_W-1:0]   red_reg, green_reg, blue_reg;

    logic running, launch, tick, h_last, v_last, frame_end, active, hs_on, vs_on;

    always_ff @(posedge clock_50 or posedge reset) begin
        if (reset) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        launch     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (vga.start) begin
                    state_next = RUN;
                    launch     = 1'b1;
                end
            end
            RUN:     state_next = RUN;
            default: state_next = IDLE;
        endcase
    end

    assign running      = (state_reg == RUN);
    assign tick         = running && (int'(div_cnt_reg) == CLK_DIV - 1);
    assign div_cnt_next = (int'(div_cnt_reg) == CLK_DIV - 1) ? '0 : div_cnt_reg + DIV_W'(1);
    assign h_last       = (int'(h_cnt_reg) == H_TOTAL - 1);
    assign v_last       = (int'(v_cnt_reg) == V_TOTAL - 1);
    assign frame_end    = tick && h_last && v_last;
    assign active       = running && (int'(h_cnt_reg) < H_ACTIVE) && (int'(v_cnt_reg) < V_ACTIVE);
    assign hs_on        = (int'(h_cnt_reg) >= HS_START) && (int'(h_cnt_reg) < HS_END);
    assign vs_on        = (int'(v_cnt_reg) >= VS_START) && (int'(v_cnt_reg) < VS_END);

    always_ff @(posedge clock_50 or posedge reset) begin
        if (reset) begin
            div_cnt_reg     <= '0;
            h_cnt_reg       <= '0;
            v_cnt_reg       <= '0;
            frame_count_reg <= '0;
            frame_start_reg <= 1'b0;
            vgaclock_reg    <= 1'b0;
            n_blank_reg     <= 1'b0;
            hsync_reg       <= ~HP;
            vsync_reg       <= ~VP;
            red_reg         <= '0;
            green_reg       <= '0;
            blue_reg        <= '0;
        end else begin
            frame_start_reg <= launch || frame_end;
            if (launch || frame_end)
                frame_count_reg <= frame_count_reg + FCNT_W'(1);
            if (running) begin
                div_cnt_reg  <= div_cnt_next;
                // Registered from the next divider value so the rising edge lands mid-pixel.
                vgaclock_reg <= (int'(div_cnt_next) >= CLK_DIV / 2);
                if (tick) begin
                    h_cnt_reg <= h_last ? '0 : h_cnt_reg + X_W'(1);
                    if (h_last)
                        v_cnt_reg <= v_last ? '0 : v_cnt_reg + Y_W'(1);
                    n_blank_reg <= active;
                    red_reg     <= active ? vga.red_in   : '0;
                    green_reg   <= active ? vga.green_in : '0;
                    blue_reg    <= active ? vga.blue_in  : '0;
                    hsync_reg   <= hs_on ? HP : ~HP;
                    vsync_reg   <= vs_on ? VP : ~VP;
                end
            end
        end
    end

    assign vga.pixel_x     = h_cnt_reg;
    assign vga.pixel_y     = v_cnt_reg;
    assign vga.pixel_req   = active;
    assign vga.red_out     = red_reg;
    assign vga.green_out   = green_reg;
    assign vga.blue_out    = blue_reg;
    assign vga.hsync       = hsync_reg;
    assign vga.vsync       = vsync_reg;
    assign vga.n_blank     = n_blank_reg;
    assign vga.vgaclock    = vgaclock_reg;
    assign vga.frame_start = frame_start_reg;
    assign vga.frame_count = frame_count_reg;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomised scoreboard bench for vga_timing_gen on a tiny 14x7 raster.
// Expected outputs come from cycle arithmetic since the last start.
module tb_vga_timing_gen;
    localparam int CLK_DIV  = 2;
    localparam int H_ACTIVE = 8, H_FP = 2, H_SYNC = 3, H_BP = 1;
    localparam int V_ACTIVE = 4, V_FP = 1, V_SYNC = 1, V_BP = 1;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int FRAME_CLKS = H_TOTAL * V_TOTAL * CLK_DIV;
    localparam int FCNT_W   = 3;

    logic clock_50 = 1'b0;
    logic reset    = 1'b1;

    vga_timing_gen_if #(.COLOR_W(8), .X_W(4), .Y_W(3), .FCNT_W(FCNT_W)) vga ();

    vga_timing_gen #(
        .COLOR_W(8), .CLK_DIV(CLK_DIV),
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .H_POL(0), .V_POL(0), .FCNT_W(FCNT_W)
    ) dut (
        .clock_50(clock_50),
        .reset(reset),
        .vga(vga.master)
    );

    initial forever #5 clock_50 = ~clock_50;

    typedef struct {
        int px, py, req, r, g, b, hs, vs, nb, vclk, fs, fc;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int passes = 0;
    bit running = 1'b0;
    int t = 0;
    logic [23:0] cap [int];

    task automatic check(string name, int act, int expv);
        checks++;
        if (act == expv) passes++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    endtask

    function automatic exp_t model(bit run, int tt);
        exp_t e;
        int p, q, hq, vq;
        bit act;
        e = '{px: 0, py: 0, req: 0, r: 0, g: 0, b: 0, hs: 1, vs: 1, nb: 0, vclk: 0, fs: 0, fc: 0};
        if (run) begin
            p      = tt / CLK_DIV;
            e.px   = p % H_TOTAL;
            e.py   = (p / H_TOTAL) % V_TOTAL;
            e.req  = (e.px < H_ACTIVE && e.py < V_ACTIVE) ? 1 : 0;
            e.vclk = ((tt % CLK_DIV) >= CLK_DIV / 2) ? 1 : 0;
            e.fs   = (tt % FRAME_CLKS == 0) ? 1 : 0;
            e.fc   = (1 + tt / FRAME_CLKS) % (1 << FCNT_W);
            if (p > 0) begin
                // DAC shows the previous pixel
                q    = p - 1;
                hq   = q % H_TOTAL;
                vq   = (q / H_TOTAL) % V_TOTAL;
                act  = (hq < H_ACTIVE) && (vq < V_ACTIVE);
                e.nb = act ? 1 : 0;
                e.r  = act ? int'(cap[q][23:16]) : 0;
                e.g  = act ? int'(cap[q][15:8])  : 0;
                e.b  = act ? int'(cap[q][7:0])   : 0;
                e.hs = (hq >= H_ACTIVE + H_FP && hq < H_ACTIVE + H_FP + H_SYNC) ? 0 : 1;
                e.vs = (vq >= V_ACTIVE + V_FP && vq < V_ACTIVE + V_FP + V_SYNC) ? 0 : 1;
            end
        end
        return e;
    endfunction

    task automatic step(bit rst, bit st, logic [23:0] col);
        bit was_running;
        @(negedge clock_50);
        reset        = rst;
        vga.start    = st;
        vga.red_in   = col[23:16];
        vga.green_in = col[15:8];
        vga.blue_in  = col[7:0];
        was_running  = running;
        if (!rst && running && (t % CLK_DIV == CLK_DIV - 1))
            cap[t / CLK_DIV] = col;
        if (rst) running = 1'b0;
        else if (!running) begin
            if (st) begin
                running = 1'b1;
                t = 0;
            end
        end else t++;
        sb.push_back(model(running, t));
        if (rst && was_running) begin
            #1;
            check("async_pixel_x",   int'(vga.pixel_x), 0);
            check("async_pixel_req", int'(vga.pixel_req), 0);
            check("async_n_blank",   int'(vga.n_blank), 0);
            check("async_hsync",     int'(vga.hsync), 1);
            check("async_vsync",     int'(vga.vsync), 1);
            check("async_red",       int'(vga.red_out), 0);
            check("async_vgaclock",  int'(vga.vgaclock), 0);
            check("async_fcount",    int'(vga.frame_count), 0);
        end
    endtask

    function automatic logic [23:0] rnd_col();
        return 24'($urandom);
    endfunction

    function automatic bit rnd_start();
        return ($urandom_range(0, 15) == 0);
    endfunction

    // Monitor: every clock the DUT presents a full output set; compare with the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock_50);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("pixel_x",     int'(vga.pixel_x), e.px);
                check("pixel_y",     int'(vga.pixel_y), e.py);
                check("pixel_req",   int'(vga.pixel_req), e.req);
                check("red_out",     int'(vga.red_out), e.r);
                check("green_out",   int'(vga.green_out), e.g);
                check("blue_out",    int'(vga.blue_out), e.b);
                check("hsync",       int'(vga.hsync), e.hs);
                check("vsync",       int'(vga.vsync), e.vs);
                check("n_blank",     int'(vga.n_blank), e.nb);
                check("vgaclock",    int'(vga.vgaclock), e.vclk);
                check("frame_start", int'(vga.frame_start), e.fs);
                check("frame_count", int'(vga.frame_count), e.fc);
            end
        end
    end

    initial begin
        vga.start    = 1'b0;
        vga.red_in   = '0;
        vga.green_in = '0;
        vga.blue_in  = '0;

        // Long reset, including start held high (reset must win)
        repeat (95) step(1'b1, 1'b0, rnd_col());
        repeat (5)  step(1'b1, 1'b1, rnd_col());
        // Idle after release: nothing moves without start
        repeat (10) step(1'b0, 1'b0, rnd_col());

        // Constant colour for two frames
        step(1'b0, 1'b1, 24'hAA550F);
        repeat (2 * FRAME_CLKS) step(1'b0, rnd_start(), 24'hAA550F);

        // Random colours and stray starts across a frame_count wrap
        repeat (8 * FRAME_CLKS) step(1'b0, rnd_start(), rnd_col());

        // Run until the DUT will show (5,2), then reset mid-line
        while (!(running && (t % CLK_DIV == 0) && ((t / CLK_DIV) % H_TOTAL == 5)
                 && (((t / CLK_DIV) / H_TOTAL) % V_TOTAL == 2)))
            step(1'b0, 1'b0, rnd_col());
        step(1'b1, 1'b0, rnd_col());
        step(1'b1, 1'b0, rnd_col());
        step(1'b0, 1'b0, rnd_col());
        step(1'b0, 1'b1, rnd_col());
        repeat (2 * FRAME_CLKS) step(1'b0, rnd_start(), rnd_col());

        // Random resets at random raster positions
        repeat (6) begin
            repeat ($urandom_range(20, 300)) step(1'b0, rnd_start(), rnd_col());
            repeat ($urandom_range(1, 3))    step(1'b1, 1'($urandom_range(0, 1)), rnd_col());
            step(1'b0, 1'b1, rnd_col());
        end
        repeat (20) step(1'b0, 1'b0, rnd_col());

        repeat (2) @(posedge clock_50);
        #2;
        checks++;
        if (sb.size() == 0) passes++;
        else $display("FAIL drain: got %0d pending expected 0", sb.size());

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised VGA raster engine; successor to the fixed 640x480 timing inside the top-level `main`.
- Derives a pixel-rate enable and vgaclock from clock_50.
- Runs horizontal/vertical counters after a start pulse, requests pixels by coordinate, and returns registered, blank-masked colour aligned with hsync/vsync/n_blank.
- Sits between the game/renderer logic and the ADV7123-style DAC pins.

Parameters:
- COLOR_W, 8, bits per colour channel
- CLK_DIV, 2, clock_50 cycles per pixel; even, >=2
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- H_POL, 0, hsync active level
- V_POL, 0, vsync active level
- FCNT_W, 16, frame counter width

Ports:
- clock_50  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  level/pulse; starts raster from IDLE
- red_in  in  COLOR_W  pixel colour for pixel_x/pixel_y
- green_in  in  COLOR_W  pixel colour
- blue_in  in  COLOR_W  pixel colour
- pixel_x  out  clog2(H_TOTAL)  current horizontal counter
- pixel_y  out  clog2(V_TOTAL)  current vertical counter
- pixel_req  out  1  high when the counters are inside the active area
- red_out  out  COLOR_W  registered colour to DAC
- green_out  out  COLOR_W  registered colour to DAC
- blue_out  out  COLOR_W  registered colour to DAC
- hsync  out  1  horizontal sync
- vsync  out  1  vertical sync
- n_blank  out  1  low during blanking
- vgaclock  out  1  pixel clock to DAC
- frame_start  out  1  one-clock_50 pulse per frame
- frame_count  out  FCNT_W  frames begun, wraps

Behaviour:
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- Reset is asynchronous, active-high. While reset is high:
  - state=IDLE
  - div_cnt, h_cnt, v_cnt, frame_count = 0
  - colours = 0, n_blank = 0, vgaclock = 0, frame_start = 0, pixel_req = 0
  - hsync = ~H_POL, vsync = ~V_POL
- FSM IDLE:
  - Outputs hold their reset values.
  - start=1 on a clock edge -> RUN.
  - On that same edge frame_start pulses and frame_count increments.
- FSM RUN:
  - Stays in RUN until reset; start is ignored.
- Divider (RUN only):
  - div_cnt counts 0..CLK_DIV-1 and wraps.
  - tick = (div_cnt == CLK_DIV-1).
  - vgaclock is registered: 1 when div_cnt >= CLK_DIV/2, else 0. The DAC therefore latches on the vgaclock rising edge, mid-pixel.
- Counters, on tick:
  - h_cnt increments; wraps at H_TOTAL-1 -> 0.
  - On the h wrap, v_cnt increments; wraps at V_TOTAL-1 -> 0.
- Frame boundary: when tick occurs with h_cnt=H_TOTAL-1 and v_cnt=V_TOTAL-1:
  - frame_start = 1 for exactly that clock_50 cycle (registered, visible the following cycle).
  - frame_count increments, modulo 2^FCNT_W.
- Request side (combinational from counter registers):
  - pixel_x = h_cnt, pixel_y = v_cnt.
  - pixel_req = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
  - The renderer has CLK_DIV-1 clock_50 cycles to settle colour inputs before tick.
- Output stage, registered on tick:
  - active = pixel_req.
  - n_blank <= active.
  - colour_out <= active ? colour_in : 0.
  - hsync <= H_POL when H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC, else ~H_POL.
  - vsync <= V_POL when V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC, else ~V_POL.
  - Latency: DAC outputs lag pixel_x/pixel_y by exactly one pixel period. Sync, blank and colour are mutually aligned.
- Between ticks all DAC outputs hold their values.
- Simultaneous reset and start: reset wins.
- Reset mid-frame returns the block to IDLE at reset values. A new start restarts at (0,0) with frame_count continuing from 0 (first frame_count = 1).

Test Plan:
Small parameters for all scenarios: CLK_DIV=2, H 8/2/3/1 (H_TOTAL=14), V 4/1/1/1 (V_TOTAL=7), polarity 0, COLOR_W=8.
1. reset=1, start=0 for 100 cycles -> hsync=vsync=1; n_blank=0; colours=0; vgaclock=0; frame_count=0; pixel_req=0. No activity after reset release until start.
2. start pulse after reset release -> frame_start one-cycle pulse, frame_count=1; vgaclock toggles period 2; pixel_x steps 0..13 every 2 cycles.
3. red_in=8'hAA constant -> red_out=AA with n_blank=1 for 8 consecutive pixels per line on lines 0-3. red_out=0 with n_blank=0 otherwise. hsync=0 for exactly 3 pixels (6 clocks), starting one pixel after pixel_x=10.
4. Run 3 frames (588 clocks) -> vsync=0 for exactly 14 pixels per frame, starting one pixel after pixel_y=5; frame_start spaced 196 clocks; frame_count=4.
5. Assert reset mid-line (pixel_x=5, pixel_y=2) -> all outputs at reset values immediately (asynchronous, before next edge). Re-start resumes at (0,0) and frame_count=1.
6. FCNT_W=2, run 5 frames -> frame_count sequence 1,2,3,0,1; start pulses during RUN change nothing.
